// File: rtl/line_render_sequencer_pkg.sv
// Shared types and constants for the line render sequencer.
// Optional overrun counter is controlled by LINE_SEQ_OVRCNT_EN.
package line_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_LINE = 9'd479;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_OVRCNT = 2'd2;

    localparam int unsigned UNIT_L1  = 0;
    localparam int unsigned UNIT_L2  = 1;
    localparam int unsigned UNIT_SPR = 2;

    // Isolates the lowest set bit; serial mode walks units in index order.
    function automatic logic [2:0] lowest_one(input logic [2:0] vec);
        return vec & (~vec + 3'd1);
    endfunction

endpackage

// File: rtl/line_render_sequencer_if.sv
// Register window bus for the line render sequencer.
interface line_render_sequencer_if;

    logic [1:0] regs_addr;
    logic [7:0] regs_wrdata;
    logic [7:0] regs_rddata;
    logic       regs_write;

    modport master (
        output regs_addr,
        output regs_wrdata,
        output regs_write,
        input  regs_rddata
    );

    modport slave (
        input  regs_addr,
        input  regs_wrdata,
        input  regs_write,
        output regs_rddata
    );

endinterface

// File: rtl/line_render_sequencer_regs.sv
// Register file: CTRL, STATUS with sticky OVERRUN, and the optional
// saturating overrun counter (built only when LINE_SEQ_OVRCNT_EN is defined).
module line_seq_regs
    import line_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] addr,
    input  logic [7:0] wrdata,
    input  logic       write,
    input  logic       busy,
    input  logic       overrun,
    output logic [7:0] rddata,
    output logic       serial
);

    logic       overrun_flag;
    logic [7:0] ovrcnt;
    logic       unused_wrdata_bits;

    assign unused_wrdata_bits = ^wrdata[7:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            serial       <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (write && addr == REG_CTRL) begin
                serial <= wrdata[0];
            end
            // A new overrun in the same cycle as a clear keeps the flag set.
            if (write && addr == REG_STATUS && wrdata[1]) begin
                overrun_flag <= 1'b0;
            end
            if (overrun) begin
                overrun_flag <= 1'b1;
            end
        end
    end

`ifdef LINE_SEQ_OVRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovrcnt <= '0;
        end else if (write && addr == REG_OVRCNT) begin
            ovrcnt <= '0;
        end else if (overrun && ovrcnt != '1) begin
            ovrcnt <= ovrcnt + 8'd1;
        end
    end
`else
    assign ovrcnt = '0;
`endif

    always_comb begin
        rddata = '0;
        case (addr)
            REG_CTRL:   rddata = {7'd0, serial};
            REG_STATUS: rddata = {6'd0, overrun_flag, busy};
            REG_OVRCNT: rddata = ovrcnt;
            default:    rddata = '0;
        endcase
    end

endmodule

// File: rtl/line_render_sequencer.sv
// Per-line render scheduler: issues start pulses to layer1/layer2/sprites,
// collects done pulses, flips line-buffer banks. Optional: LINE_SEQ_OVRCNT_EN.
module line_render_sequencer
    import line_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    line_render_sequencer_if.slave  regs,
    input  logic [8:0]              display_line_idx,
    input  logic                    display_start_of_line,
    input  logic                    layer1_enabled,
    input  logic                    layer2_enabled,
    input  logic                    sprites_enabled,
    input  logic                    layer1_line_render_done,
    input  logic                    layer2_line_render_done,
    input  logic                    sprites_line_render_done,
    output logic [8:0]              render_line_idx,
    output logic                    layer1_line_render_start,
    output logic                    layer2_line_render_start,
    output logic                    sprites_line_render_start,
    output logic                    lb_render_bank,
    output logic                    lb_display_bank,
    output logic                    busy
);

    state_t     state;
    logic [2:0] pend;
    logic [2:0] start_vec;
    logic       serial_lat;
    logic       serial;
    logic [2:0] en_vec;
    logic [2:0] done_vec;
    logic [2:0] accept;
    logic [2:0] cleared;
    logic [2:0] pend_next;
    logic       overrun_evt;

    assign en_vec   = {sprites_enabled, layer2_enabled, layer1_enabled};
    assign done_vec = {sprites_line_render_done, layer2_line_render_done,
                       layer1_line_render_done};

    assign layer1_line_render_start  = start_vec[UNIT_L1];
    assign layer2_line_render_start  = start_vec[UNIT_L2];
    assign sprites_line_render_start = start_vec[UNIT_SPR];
    assign lb_display_bank           = ~lb_render_bank;

    // pend_next includes this cycle's done pulses, so a final done that
    // coincides with start-of-line does not count as an overrun.
    always_comb begin
        accept      = serial_lat ? lowest_one(pend) : pend;
        cleared     = done_vec & accept;
        pend_next   = pend & ~cleared;
        overrun_evt = display_start_of_line && (state != ST_IDLE) &&
                      (pend_next != '0);
    end

    // Start pulses are registered on the transition into START, so START is
    // the cycle in which they are visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pend            <= '0;
            start_vec       <= '0;
            serial_lat      <= 1'b0;
            render_line_idx <= '0;
            lb_render_bank  <= 1'b0;
            busy            <= 1'b0;
        end else begin
            start_vec <= '0;
            if (display_start_of_line) begin
                render_line_idx <= (display_line_idx == LAST_LINE) ? '0
                                   : display_line_idx + 9'd1;
                lb_render_bank  <= ~lb_render_bank;
                serial_lat      <= serial;
                pend            <= en_vec;
                start_vec       <= serial ? lowest_one(en_vec) : en_vec;
                busy            <= |en_vec;
                state           <= (|en_vec) ? ST_START : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_START, ST_WAIT: begin
                        pend <= pend_next;
                        if (pend_next == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (serial_lat && cleared != '0) begin
                            start_vec <= lowest_one(pend_next);
                            state     <= ST_START;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        pend  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    line_seq_regs u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (regs.regs_addr),
        .wrdata  (regs.regs_wrdata),
        .write   (regs.regs_write),
        .busy    (busy),
        .overrun (overrun_evt),
        .rddata  (regs.regs_rddata),
        .serial  (serial)
    );

endmodule
